// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller bus.
// stall_cycles/flush_count exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int PERF_W = 32)
`endif
  ;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, branch_taken, mem_busy;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles, flush_count;
`endif
  modport master(
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_busy,
    input pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );
  modport slave(
    input id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-wait hold control for the MIPS pipe.
// Optional saturating perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_W = 32
) (
  input logic clock,
  input logic reset,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT} state_t;
  state_t state_q, state_d, eff;
  logic [1:0] cnt_q, cnt_d;
  logic resume_q, resume_d, lu, stall, flush, hold;
  logic pc_write;
  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3 || PERF_W < 1) begin : g_param_chk
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be 1..3 and PERF_W >= 1");
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= 2'd0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  always_comb begin
    lu = bus.ex_memread && bus.ex_rt != 5'd0 &&
         (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
    // leaving MEMWAIT behaves as if already back in the interrupted state
    eff = (state_q == MEMWAIT) ? (resume_q ? LOADUSE : RUN) : state_q;
    state_d = eff;
    cnt_d = cnt_q;
    resume_d = resume_q;
    stall = 1'b0;
    flush = 1'b0;
    hold = 1'b0;
    if (bus.mem_busy) begin
      hold = 1'b1;
      state_d = MEMWAIT;
      resume_d = (state_q == MEMWAIT) ? resume_q : (state_q == LOADUSE);
    end else if (bus.branch_taken) begin
      flush = 1'b1;
      state_d = RUN;
      cnt_d = 2'd0;
    end else if (eff == LOADUSE) begin
      stall = 1'b1;
      state_d = (cnt_q == 2'd0) ? RUN : LOADUSE;
      cnt_d = (cnt_q == 2'd0) ? cnt_q : cnt_q - 2'd1;
    end else if (lu) begin
      stall = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = LOADUSE;
        cnt_d = 2'(LOAD_STALL_CYCLES - 2);
      end
    end
  end
  assign pc_write        = !reset && !hold && !stall;
  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = pc_write;
  assign bus.idex_bubble = !reset && stall;
  assign bus.ifid_flush  = !reset && flush;
  assign bus.idex_flush  = !reset && flush;
  assign bus.pipe_hold   = reset || hold;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, flush_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && !(&stall_q)) stall_q <= stall_q + PERF_W'(1);
      if (flush && !(&flush_q)) flush_q <= flush_q + PERF_W'(1);
    end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with LOAD_STALL_CYCLES = 1 and 3 side by side.
module tb_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [5:0] NORM  = 6'b011000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] FLUSH = 6'b011011;
  localparam logic [5:0] HOLD  = 6'b100000;
  always #5 clock = ~clock;
`ifdef HAZARD_PERF_CNT_EN
  hazard_ctrl_if b1();
  hazard_ctrl_if #(.PERF_W(4)) b3();
`else
  hazard_ctrl_if b1();
  hazard_ctrl_if b3();
`endif
  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u1(.clock(clock), .reset(reset), .bus(b1.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .PERF_W(4)) u3(.clock(clock), .reset(reset), .bus(b3.slave));

  function automatic logic [5:0] o1();
    return {b1.pipe_hold, b1.pc_write, b1.ifid_write, b1.idex_bubble, b1.ifid_flush, b1.idex_flush};
  endfunction
  function automatic logic [5:0] o3();
    return {b3.pipe_hold, b3.pc_write, b3.ifid_write, b3.idex_bubble, b3.ifid_flush, b3.idex_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic both(input string tag, input logic [5:0] e1, input logic [5:0] e3);
    chk({tag, "/u1"}, 32'(o1()), 32'(e1));
    chk({tag, "/u3"}, 32'(o3()), 32'(e3));
  endtask
  task automatic drive(input logic mr, input logic [4:0] ert, rs, rt, input logic ur, br, busy);
    b1.ex_memread = mr; b1.ex_rt = ert; b1.id_rs = rs; b1.id_rt = rt;
    b1.id_uses_rt = ur; b1.branch_taken = br; b1.mem_busy = busy;
    b3.ex_memread = mr; b3.ex_rt = ert; b3.id_rs = rs; b3.id_rt = rt;
    b3.id_uses_rt = ur; b3.branch_taken = br; b3.mem_busy = busy;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    both("reset", HOLD, HOLD);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset stall_cycles", 32'(b3.stall_cycles), 32'd0);
    chk("reset flush_count", 32'(b3.flush_count), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    idle();
    both("run idle", NORM, NORM);
    tick();
    // load-use through rs
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    both("lu_rs c1", STALL, STALL);
    tick();
    idle(); both("lu_rs c2", NORM, STALL); tick();
    idle(); both("lu_rs c3", NORM, STALL); tick();
    idle(); both("lu_rs c4", NORM, NORM); tick();
    // load-use through rt
    drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    both("lu_rt c1", STALL, STALL);
    tick();
    idle(); both("lu_rt c2", NORM, STALL); tick();
    idle(); both("lu_rt c3", NORM, STALL); tick();
    idle(); both("lu_rt c4", NORM, NORM); tick();
    drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
    both("rt unused", NORM, NORM);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    both("ex_rt zero", NORM, NORM);
    tick();
    drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
    both("no memread", NORM, NORM);
    tick();
    // mem_busy interrupting the second stall cycle
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    both("mw stall1", STALL, STALL);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      both($sformatf("mw hold%0d", i), HOLD, HOLD);
      tick();
    end
    idle(); both("mw stall2", NORM, STALL); tick();
    idle(); both("mw stall3", NORM, STALL); tick();
    idle(); both("mw run", NORM, NORM); tick();
    // branch aborting a load-use stall
    do_reset();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    both("br stall1", STALL, STALL);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    both("br flush", FLUSH, FLUSH);
    tick();
    idle();
    both("br after", NORM, NORM);
`ifdef HAZARD_PERF_CNT_EN
    chk("flush_count one", 32'(b3.flush_count), 32'd1);
`endif
    tick();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    both("br beats lu", FLUSH, FLUSH);
    tick();
    idle(); both("br lu after", NORM, NORM); tick();
    // reset in the middle of a memory wait
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    both("rw stall1", STALL, STALL);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); both("rw hold1", HOLD, HOLD); tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); both("rw hold2", HOLD, HOLD);
    reset = 1'b1;
    idle();
    both("rw reset1", HOLD, HOLD);
`ifdef HAZARD_PERF_CNT_EN
    chk("rw stall_cycles", 32'(b3.stall_cycles), 32'd0);
    chk("rw flush_count", 32'(b3.flush_count), 32'd0);
`endif
    tick();
    both("rw reset2", HOLD, HOLD);
    tick();
    reset = 1'b0;
    idle(); both("rw release", NORM, NORM); tick();
    idle(); both("rw run", NORM, NORM); tick();
`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_cycles 3", 32'(b3.stall_cycles), 32'd3);
    for (int i = 0; i < 18; i++) tick();
    chk("stall_cycles sat", 32'(b3.stall_cycles), 32'hF);
    chk("stall_cycles wide", b1.stall_cycles, 32'd21);
    idle();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
